// File: rtl/mac_accum_if.sv
// Handshake bundle between the multiplier-side producer and the mac_accum stage.
interface mac_accum_if #(
   parameter int unsigned ACC_W = 48,
   parameter int unsigned LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             sgn;
   logic             prod_vld;
   logic [35:0]      prod;
   logic             busy;
   logic [ACC_W-1:0] acc;
   logic             acc_vld;
   logic             acc_rdy;
   logic             ovf;

   modport master (
      output start, len, sgn, prod_vld, prod, acc_rdy,
      input  busy, acc, acc_vld, ovf
   );

   modport slave (
      input  start, len, sgn, prod_vld, prod, acc_rdy,
      output busy, acc, acc_vld, ovf
   );
endinterface

// File: rtl/mac_accum.sv
// Sums a programmed number of 36-bit products into an ACC_W accumulator with overflow flag.
// Define MAC_ACC_SAT_EN to clamp on overflow instead of wrapping.
module mac_accum #(
   parameter int unsigned ACC_W = 48,
   parameter int unsigned LEN_W = 8
) (
   input logic        i_clk,
   input logic        i_rstn,
   mac_accum_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t           state, state_nx;
   logic [ACC_W-1:0] acc_q, acc_nx;
   logic [LEN_W-1:0] cnt_q, cnt_nx;
   logic             sgn_q, sgn_nx;
   logic             ovf_q, ovf_nx;

   logic [ACC_W-1:0] ext;
   logic [ACC_W:0]   sum;
   logic             ovf_term;
   logic [ACC_W-1:0] term;
   logic             start_ok;
   logic             load;

   assign start_ok = bus.start && (bus.len != '0);

   // Size cast keeps the operand's signedness, so this sign- or zero-extends.
   assign ext = sgn_q ? ACC_W'($signed(bus.prod)) : ACC_W'(bus.prod);
   assign sum = {1'b0, acc_q} + {1'b0, ext};

   always_comb begin
      ovf_term = 1'b0;
      if (sgn_q)
         ovf_term = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
      else
         ovf_term = sum[ACC_W];
   end

`ifdef MAC_ACC_SAT_EN
   always_comb begin
      term = sum[ACC_W-1:0];
      if (ovf_term) begin
         if (!sgn_q)
            term = '1;
         else if (acc_q[ACC_W-1])
            term = {1'b1, {(ACC_W-1){1'b0}}};
         else
            term = {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign term = sum[ACC_W-1:0];
`endif

   always_comb begin
      state_nx = state;
      acc_nx   = acc_q;
      cnt_nx   = cnt_q;
      sgn_nx   = sgn_q;
      ovf_nx   = ovf_q;
      load     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_ok)
               load = 1'b1;
         end
         ACC: begin
            if (bus.prod_vld) begin
               acc_nx = term;
               ovf_nx = ovf_q | ovf_term;
               cnt_nx = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1))
                  state_nx = DONE;
            end
         end
         DONE: begin
            if (bus.acc_rdy) begin
               if (start_ok)
                  load = 1'b1;
               else
                  state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      // Shared by the IDLE start and the back-to-back start taken on the DONE handshake.
      if (load) begin
         state_nx = ACC;
         cnt_nx   = bus.len;
         sgn_nx   = bus.sgn;
         acc_nx   = '0;
         ovf_nx   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= IDLE;
         acc_q <= '0;
         cnt_q <= '0;
         sgn_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nx;
         acc_q <= acc_nx;
         cnt_q <= cnt_nx;
         sgn_q <= sgn_nx;
         ovf_q <= ovf_nx;
      end
   end

   assign bus.busy    = (state != IDLE);
   assign bus.acc_vld = (state == DONE);
   assign bus.acc     = acc_q;
   assign bus.ovf     = ovf_q;

endmodule
